// File: rtl/key_encode.sv
// key_encode: recovers the 2-bit index from a 4-line active-low one-cold group.
// Path: 2-flop synchronizer, group debouncer, registered priority encoder with press/release pulses.
module key_encode #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] k_n_i,
  input  logic       e_i,
  output logic [1:0] code_o,
  output logic       valid_o,
  output logic       multi_o,
  output logic       press_o,
  output logic       release_o
);

  localparam int unsigned LINES = 4;
  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  logic [LINES-1:0] s1_q, s2_q;
  logic [LINES-1:0] cand_q, cand_d;
  logic [LINES-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;

  logic [IDX_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  logic [LINES-1:0] asserted_c;
  logic [IDX_W-1:0] low_idx_c;
  logic             any_c;
  logic             old_any_c;

  // Debounce: a new synchronized pattern must hold DEB_CYCLES edges past capture.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept_c = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cand_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = cand_q;
      cnt_d    = '0;
      accept_c = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Encoder works on the value being written to stable.
  always_comb begin
    asserted_c = ~stable_d;
    any_c      = |asserted_c;
    old_any_c  = |(~stable_q);
    low_idx_c  = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (asserted_c[i]) low_idx_c = IDX_W'(i);
    end
  end

  always_comb begin
    code_d    = any_c ? low_idx_c : code_q;
    valid_d   = any_c & ~e_i;
    // More than one bit set iff clearing the lowest set bit leaves something.
    multi_d   = ((asserted_c & (asserted_c - LINES'(1))) != '0) & ~e_i;
    press_d   = accept_c & ~e_i & any_c & (~old_any_c | (low_idx_c != code_q));
    release_d = accept_c & ~e_i & old_any_c & ~any_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '1;
      s2_q      <= '1;
      cand_q    <= '1;
      stable_q  <= '1;
      cnt_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= k_n_i;
      s2_q      <= s1_q;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = valid_q;
  assign multi_o   = multi_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_key_encode.sv
// tb_key_encode: directed and random stimulus for key_encode against a
// history-based reference model (acceptance = last DEB+1 synchronized samples agree).
module tb_key_encode;

  localparam int unsigned DEB   = 4;
  localparam int unsigned CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] k_n = 4'hF;
  logic       e   = 1'b0;
  logic [1:0] code_o;
  logic       valid_o, multi_o, press_o, release_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_press = 0;
  int n_rel   = 0;

  // reference model state
  logic [3:0] m_s1, m_s2, m_stable;
  logic [3:0] hist[$];
  logic [1:0] m_code;
  logic       m_valid, m_multi, m_press, m_rel, m_eprev;

  key_encode #(.DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .k_n_i(k_n), .e_i(e),
    .code_o(code_o), .valid_o(valid_o), .multi_o(multi_o),
    .press_o(press_o), .release_o(release_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF;
    hist.delete();
    m_code = 2'd0; m_valid = 0; m_multi = 0; m_press = 0; m_rel = 0; m_eprev = 0;
  endtask

  task automatic model_step();
    logic [3:0] pre, p;
    logic       same, nv, old_raw;
    logic [1:0] nc;
    pre  = m_s2;
    m_s2 = m_s1;
    m_s1 = k_n;
    hist.push_back(pre);
    if (hist.size() > DEB + 1) void'(hist.pop_front());
    p    = hist[0];
    same = (hist.size() == DEB + 1);
    foreach (hist[i]) if (hist[i] != p) same = 0;
    m_press = 0;
    m_rel   = 0;
    if (same && p != m_stable) begin
      nv      = (p != 4'hF);
      old_raw = (m_stable != 4'hF);
      nc      = nv ? lowest(p) : m_code;
      m_press = !e && nv && (!old_raw || nc != m_code);
      m_rel   = !e && old_raw && !nv;
      m_valid = nv && !e;
      m_multi = ($countones(~p) > 1) && !e;
      m_code  = nc;
      m_stable = p;
    end else if (e) begin
      m_valid = 0;
      m_multi = 0;
    end else if (m_eprev) begin
      m_valid = (m_stable != 4'hF);
      m_multi = ($countones(~m_stable) > 1);
    end
    m_eprev = e;
  endtask

  // One clock: drive at negedge, model at posedge, compare #1 later.
  task automatic step(input logic [3:0] k, input logic ev);
    k_n = k;
    e   = ev;
    @(posedge clk);
    model_step();
    #1;
    check("code", 32'(code_o), 32'(m_code));
    check("valid", 32'(valid_o), 32'(m_valid));
    check("multi", 32'(multi_o), 32'(m_multi));
    check("press", 32'(press_o), 32'(m_press));
    check("release", 32'(release_o), 32'(m_rel));
    if (press_o) n_press++;
    if (release_o) n_rel++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] k, input logic ev, input int n);
    for (int i = 0; i < n; i++) step(k, ev);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_code", 32'(code_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_multi", 32'(multi_o), 32'd0);
    check("rst_press", 32'(press_o), 32'd0);
    check("rst_release", 32'(release_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clr();
    n_press = 0;
    n_rel   = 0;
  endtask

  initial begin
    logic [3:0] pats[8];
    logic [3:0] p;
    logic       ev;
    pats = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'h6, 4'h0};

    do_reset();
    clr();
    hold(4'hF, 0, 20);
    check("idle_press", 32'(n_press), 32'd0);
    check("idle_rel", 32'(n_rel), 32'd0);

    // line 2 press: update lands on the 7th edge after the change
    clr();
    hold(4'hB, 0, 6);
    check("lat_valid_early", 32'(valid_o), 32'd0);
    step(4'hB, 0);
    check("lat_valid", 32'(valid_o), 32'd1);
    check("lat_code", 32'(code_o), 32'd2);
    hold(4'hB, 0, 5);
    check("p2_press_cnt", 32'(n_press), 32'd1);
    clr();
    hold(4'hF, 0, 10);
    check("p2_rel_cnt", 32'(n_rel), 32'd1);
    check("p2_code_kept", 32'(code_o), 32'd2);

    // glitch shorter than debounce
    clr();
    hold(4'hD, 0, 3);
    hold(4'hF, 0, 10);
    check("glitch_press", 32'(n_press), 32'd0);
    check("glitch_valid", 32'(valid_o), 32'd0);

    // multi-hit, then same code without press
    clr();
    hold(4'h6, 0, 10);
    check("multi_set", 32'(multi_o), 32'd1);
    check("multi_press", 32'(n_press), 32'd1);
    clr();
    hold(4'hE, 0, 10);
    check("same_code_press", 32'(n_press), 32'd0);
    check("same_code_multi", 32'(multi_o), 32'd0);
    clr();
    hold(4'h7, 0, 10);
    check("switch_code", 32'(code_o), 32'd3);
    check("switch_press", 32'(n_press), 32'd1);
    check("switch_rel", 32'(n_rel), 32'd0);

    // disable
    hold(4'hF, 0, 10);
    clr();
    hold(4'hD, 1, 10);
    check("dis_valid", 32'(valid_o), 32'd0);
    step(4'hD, 0);
    check("en_valid", 32'(valid_o), 32'd1);
    check("en_code", 32'(code_o), 32'd1);
    check("en_press", 32'(n_press), 32'd0);

    // reset mid-count, release with a line already low
    hold(4'hB, 0, 3);
    do_reset();
    clr();
    hold(4'hB, 0, 10);
    check("post_rst_press", 32'(n_press), 32'd1);
    check("post_rst_code", 32'(code_o), 32'd2);

    // random segments with occasional disable and reset
    for (int s = 0; s < 400; s++) begin
      p  = pats[$urandom_range(0, 7)];
      ev = ($urandom_range(0, 9) == 0);
      hold(p, ev, $urandom_range(1, 9));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
